// File: rtl/comp_iter_if.sv
// rtl/comp_iter_if.sv - operand/result handshake bundle for comp_iter
interface comp_iter_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic         a_eq_b;
  logic         a_gt_b;
  logic         a_lt_b;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, a_eq_b, a_gt_b, a_lt_b
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, a_eq_b, a_gt_b, a_lt_b
  );
endinterface

// File: rtl/comp_iter.sv
// rtl/comp_iter.sv - multi-cycle N-bit comparator, W bits per cycle from the MSB chunk down
// COMP_ITER_EARLY_EXIT_EN: finish on the first differing chunk instead of always scanning K chunks
module comp_iter #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  comp_iter_if.slave  bus
);
  localparam int K  = (W > 0) ? N / W : 1;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [31:0] WU = W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("comp_iter: W must divide N and satisfy 1 <= W <= N");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;

  logic [31:0]   shamt;
  logic [N-1:0]  a_sh, b_sh;
  logic [W-1:0]  a_chunk, b_chunk;
  logic          chunk_diff, chunk_gt, recorded, leave_run;

  // Current chunk is brought down to bit 0 so the compare is a fixed W-bit one
  assign shamt      = 32'(idx_q) * WU;
  assign a_sh       = a_q >> shamt;
  assign b_sh       = b_q >> shamt;
  assign a_chunk    = a_sh[W-1:0];
  assign b_chunk    = b_sh[W-1:0];
  assign chunk_diff = (a_chunk != b_chunk);
  assign chunk_gt   = (a_chunk > b_chunk);
  assign recorded   = gt_q | lt_q;

  always_comb begin
    leave_run = (idx_q == '0);
`ifdef COMP_ITER_EARLY_EXIT_EN
    if (chunk_diff) begin
      leave_run = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d = bus.a;
          b_d = bus.b;
          // Flipping the sign bits maps two's-complement order onto unsigned order
          if (bus.is_signed) begin
            a_d[N-1] = ~bus.a[N-1];
            b_d[N-1] = ~bus.b[N-1];
          end
          idx_d   = IW'(K - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!recorded && chunk_diff) begin
          gt_d = chunk_gt;
          lt_d = ~chunk_gt;
        end
        if (leave_run) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // Flags are gated by DONE so they read 0 whenever no result is offered
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.a_gt_b    = (state_q == S_DONE) & gt_q;
  assign bus.a_lt_b    = (state_q == S_DONE) & lt_q;
  assign bus.a_eq_b    = (state_q == S_DONE) & ~gt_q & ~lt_q;
endmodule

// File: tb/tb_comp_iter.sv
// tb/tb_comp_iter.sv - directed and swept checks of comp_iter for W = 8, 1, 4, 32
module tb_comp_iter;
  logic clk = 1'b0;
  logic rst;
  logic sweep_en;
  int   errors = 0;
  int   checks = 0;

`ifdef COMP_ITER_EARLY_EXIT_EN
  localparam int EXP_SIGNED_LAT = 1;
`else
  localparam int EXP_SIGNED_LAT = 4;
`endif

  always #5 clk = ~clk;

  comp_iter_if #(.N(32)) m_if ();
  comp_iter_if #(.N(32)) s1_if ();
  comp_iter_if #(.N(32)) s4_if ();
  comp_iter_if #(.N(32)) s32_if ();

  assign s1_if.in_valid   = m_if.in_valid & sweep_en;
  assign s1_if.a          = m_if.a;
  assign s1_if.b          = m_if.b;
  assign s1_if.is_signed  = m_if.is_signed;
  assign s1_if.out_ready  = m_if.out_ready;
  assign s4_if.in_valid   = m_if.in_valid & sweep_en;
  assign s4_if.a          = m_if.a;
  assign s4_if.b          = m_if.b;
  assign s4_if.is_signed  = m_if.is_signed;
  assign s4_if.out_ready  = m_if.out_ready;
  assign s32_if.in_valid  = m_if.in_valid & sweep_en;
  assign s32_if.a         = m_if.a;
  assign s32_if.b         = m_if.b;
  assign s32_if.is_signed = m_if.is_signed;
  assign s32_if.out_ready = m_if.out_ready;

  comp_iter #(.N(32), .W(8))  dut   (.clk(clk), .rst(rst), .bus(m_if.slave));
  comp_iter #(.N(32), .W(1))  dut1  (.clk(clk), .rst(rst), .bus(s1_if.slave));
  comp_iter #(.N(32), .W(4))  dut4  (.clk(clk), .rst(rst), .bus(s4_if.slave));
  comp_iter #(.N(32), .W(32)) dut32 (.clk(clk), .rst(rst), .bus(s32_if.slave));

  task automatic start_txn(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    m_if.a         = ta;
    m_if.b         = tb_v;
    m_if.is_signed = ts;
    m_if.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    m_if.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!m_if.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!m_if.out_valid) lat = -1;
  endtask

  task automatic release_out();
    m_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({m_if.in_ready, m_if.out_valid, m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_state: got rdy/vld/eq/gt/lt=%b want 10000",
               {m_if.in_ready, m_if.out_valid, m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
    end
    start_txn(32'h0000_0001, 32'h0000_0002, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({m_if.out_valid, m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_run_%0d: got vld/eq/gt/lt=%b want 0000", i,
                 {m_if.out_valid, m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", m_if.in_ready);
    end
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_if.out_valid !== 1'b0) lat++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL reset_no_stale: got %0d valid cycles want 0", lat);
    end
  endtask

  task automatic test_equal();
    int lat;
    start_txn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    wait_result(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL equal_latency: got %0d want 4", lat);
    end
    checks++;
    if ({m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 3'b100) begin
      errors++;
      $display("FAIL equal_flags: got eq/gt/lt=%b want 100", {m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
    end
    release_out();
  endtask

  task automatic test_signed();
    int lat;
    start_txn(32'h8000_0000, 32'h0000_0001, 1'b0);
    wait_result(lat);
    checks++;
    if (lat != EXP_SIGNED_LAT) begin
      errors++;
      $display("FAIL unsigned_latency: got %0d want %0d", lat, EXP_SIGNED_LAT);
    end
    checks++;
    if ({m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 3'b010) begin
      errors++;
      $display("FAIL unsigned_flags: got eq/gt/lt=%b want 010", {m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
    end
    release_out();
    start_txn(32'h8000_0000, 32'h0000_0001, 1'b1);
    wait_result(lat);
    checks++;
    if (lat != EXP_SIGNED_LAT) begin
      errors++;
      $display("FAIL signed_latency: got %0d want %0d", lat, EXP_SIGNED_LAT);
    end
    checks++;
    if ({m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 3'b001) begin
      errors++;
      $display("FAIL signed_flags: got eq/gt/lt=%b want 001", {m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
    end
    release_out();
  endtask

  task automatic test_lsb();
    int lat;
    start_txn(32'h1234_5678, 32'h1234_5677, 1'b0);
    wait_result(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL lsb_latency: got %0d want 4", lat);
    end
    checks++;
    if ({m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 3'b010) begin
      errors++;
      $display("FAIL lsb_flags: got eq/gt/lt=%b want 010", {m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    start_txn(32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      m_if.a        = 32'h0000_0001 << i;
      m_if.b        = 32'hFFFF_FFFF;
      m_if.in_valid = i[0];
      @(posedge clk);
      #1;
      checks++;
      if ({m_if.in_ready, m_if.out_valid, m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 5'b01010) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got rdy/vld/eq/gt/lt=%b want 01010", i,
                 {m_if.in_ready, m_if.out_valid, m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
      end
    end
    m_if.in_valid = 1'b0;
    release_out();
    checks++;
    if ({m_if.in_ready, m_if.out_valid, m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 5'b10000) begin
      errors++;
      $display("FAIL backpressure_release: got rdy/vld/eq/gt/lt=%b want 10000",
               {m_if.in_ready, m_if.out_valid, m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_txn(32'h0000_0007, 32'h0000_0009, 1'b0);
    wait_result(lat);
    checks++;
    if ({m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_first_flags: got eq/gt/lt=%b want 001", {m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
    end
    m_if.a         = 32'h0000_0009;
    m_if.b         = 32'h0000_0007;
    m_if.is_signed = 1'b0;
    m_if.in_valid  = 1'b1;
    release_out();
    checks++;
    if (m_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1", m_if.in_ready);
    end
    @(posedge clk);
    #1;
    m_if.in_valid = 1'b0;
    wait_result(lat);
    checks++;
    if (lat != 4 || {m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d eq/gt/lt=%b want lat=4 010",
               lat, {m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b});
    end
    release_out();
  endtask

  task automatic test_sweep();
    logic [31:0]        va, vb;
    logic               vs;
    logic signed [31:0] sa, sb;
    logic [2:0]         exp;
    int                 cyc;
    sweep_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      va = $urandom;
      vb = (i % 32 == 0) ? va : $urandom;
      if (i % 7 == 3) vb[31:8] = va[31:8];
      vs = 1'($urandom_range(0, 1));
      sa = va;
      sb = vb;
      if (vs) exp = {sa == sb, sa > sb, sa < sb};
      else    exp = {va == vb, va > vb, va < vb};
      start_txn(va, vb, vs);
      cyc = 0;
      while (!(m_if.out_valid && s1_if.out_valid && s4_if.out_valid && s32_if.out_valid) && cyc < 200) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      checks++;
      if (cyc >= 200) begin
        errors++;
        $display("FAIL sweep_timeout_%0d: valids=%b want 1111", i,
                 {m_if.out_valid, s1_if.out_valid, s4_if.out_valid, s32_if.out_valid});
      end
      checks++;
      if ({m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b} !== exp) begin
        errors++;
        $display("FAIL sweep_w8_%0d: a=%h b=%h s=%b got %b want %b", i, va, vb, vs,
                 {m_if.a_eq_b, m_if.a_gt_b, m_if.a_lt_b}, exp);
      end
      checks++;
      if ({s1_if.a_eq_b, s1_if.a_gt_b, s1_if.a_lt_b} !== exp) begin
        errors++;
        $display("FAIL sweep_w1_%0d: a=%h b=%h s=%b got %b want %b", i, va, vb, vs,
                 {s1_if.a_eq_b, s1_if.a_gt_b, s1_if.a_lt_b}, exp);
      end
      checks++;
      if ({s4_if.a_eq_b, s4_if.a_gt_b, s4_if.a_lt_b} !== exp) begin
        errors++;
        $display("FAIL sweep_w4_%0d: a=%h b=%h s=%b got %b want %b", i, va, vb, vs,
                 {s4_if.a_eq_b, s4_if.a_gt_b, s4_if.a_lt_b}, exp);
      end
      checks++;
      if ({s32_if.a_eq_b, s32_if.a_gt_b, s32_if.a_lt_b} !== exp) begin
        errors++;
        $display("FAIL sweep_w32_%0d: a=%h b=%h s=%b got %b want %b", i, va, vb, vs,
                 {s32_if.a_eq_b, s32_if.a_gt_b, s32_if.a_lt_b}, exp);
      end
      release_out();
    end
    sweep_en = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    sweep_en       = 1'b0;
    m_if.in_valid  = 1'b0;
    m_if.out_ready = 1'b0;
    m_if.a         = '0;
    m_if.b         = '0;
    m_if.is_signed = 1'b0;
    test_reset();
    test_equal();
    test_signed();
    test_lsb();
    test_backpressure();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/comp_iter.md
# comp_iter

Multi-cycle magnitude comparator: the parametrised successor of the combinational `comp_eq`/`comp_gt`/`comp_lt` family. It compares two N-bit operands W bits per cycle, starting at the MSB chunk, and supports unsigned and two's-complement signed modes per transaction. Operands and results move over valid/ready handshakes. The block serves datapaths where a full-width single-cycle comparator would break timing or cost too much area.

## Interface
- `N`, 32: operand width.
- `W`, 8: chunk width compared per cycle. `N % W == 0` and `1 <= W <= N` are required; any other value is an elaboration `$error`. `K = N/W` is the chunk count.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `a`  in  N  operand A, sampled on input handshake.
- `b`  in  N  operand B, sampled on input handshake.
- `is_signed`  in  1  1 = two's-complement compare, 0 = unsigned; sampled on input handshake.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `a_eq_b`  out  1  a == b.
- `a_gt_b`  out  1  a > b.
- `a_lt_b`  out  1  a < b.

## Operation
- FSM states: IDLE, RUN, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- IDLE, `in_valid`=1:
  - register `a` and `b`.
  - if `is_signed`, invert bit N-1 of both captured operands, so the signed compare becomes an unsigned compare.
  - set chunk index `idx` = K-1 and go to RUN.
- RUN, per cycle: compare chunks `a[idx*W +: W]` and `b[idx*W +: W]`.
  - Record the first differing chunk only: gt if a chunk > b chunk, lt otherwise. Later chunks never overwrite the recorded result.
  - Early exit is governed by `COMP_ITER_EARLY_EXIT_EN` (see Configuration).
  - When `idx` == 0 with nothing recorded, the result is eq.
  - Leaving RUN: go to DONE and `idx` stops. Otherwise `idx` decrements.
- DONE: exactly one of `a_eq_b`/`a_gt_b`/`a_lt_b` is 1. Outputs are held stable while `out_ready`=0. On `out_ready`=1 the flags clear and the state returns to IDLE.
- Flags are all 0 whenever `out_valid`=0.
- Inputs `a`, `b` and `is_signed` are ignored outside the IDLE handshake. Changing them mid-RUN has no effect.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - state IDLE, so `in_ready`=1.
  - `out_valid`=0.
  - all flags 0, `idx`=0.
- Reset mid-RUN or mid-DONE aborts the transaction and no result is produced. `rst` has priority over every handshake in the same cycle.
- Input handshake at edge t: RUN begins cycle t+1.
- Latency from input handshake to `out_valid`=1:
  - fixed mode: K cycles.
  - early-exit mode: j cycles, where j is the number of chunks examined, 1..K.
- Output handshake at edge u: IDLE at u+1. The next input handshake can occur at edge u+1 at the earliest.
- No overlap of transactions. The minimum initiation interval is latency + 2 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.

## Configuration
- `COMP_ITER_EARLY_EXIT_EN` defined: RUN goes to DONE in the same cycle the first differing chunk is found. Latency is data-dependent, 1..K.
- Not defined: RUN always processes all K chunks. Latency is a fixed K for every operand pair. The result is identical to the early-exit mode.

## Test plan
- Reset: assert `rst` for 2 cycles during RUN with N=32, W=8. Required: `out_valid`=0 throughout, flags 0, `in_ready`=1 on the first cycle after release, no stale result afterwards.
- Equal: `a`=`b`=32'hDEADBEEF, unsigned. Required: `a_eq_b`=1 after exactly 4 cycles in both configurations.
- Signed/unsigned: `a`=32'h80000000, `b`=32'h00000001.
  - `is_signed`=0: `a_gt_b`=1.
  - `is_signed`=1: `a_lt_b`=1.
  - Latency is 1 cycle with `COMP_ITER_EARLY_EXIT_EN` and 4 cycles without.
- LSB difference: `a`=32'h12345678, `b`=32'h12345677. Required: `a_gt_b`=1 with latency 4 in both configurations.
- Backpressure: hold `out_ready`=0 for 5 cycles while `out_valid`=1 and toggle `a`/`b`/`in_valid`. Required: flags stable, `in_ready`=0, no new capture. Release: IDLE next cycle.
- Random sweep: 512 vectors with random `is_signed`, and `b`=`a` on every 32nd vector. Each result is checked against the `==`/`>`/`<` reference, `$signed` when `is_signed`=1. Repeat for W ∈ {1, 4, 32} with N=32.
